// File: rtl/supervision_pkg.sv
// Shared constants for the Supervision video subsystem: VRAM geometry,
// arbiter FSM states and the four-shade LCD palette.
package supervision_pkg;

  localparam int VRAM_AW    = 13;
  localparam int VRAM_DW    = 8;
  localparam int VRAM_DEPTH = 1 << VRAM_AW;

  typedef enum logic [1:0] {IDLE, PEND, DONE} arb_state_e;

  // 12-bit RGB shades, lightest to darkest, indexed by the 2-bit pixel code
  localparam logic [11:0] LCD_PAL_0 = 12'hEFE;
  localparam logic [11:0] LCD_PAL_1 = 12'hABA;
  localparam logic [11:0] LCD_PAL_2 = 12'h676;
  localparam logic [11:0] LCD_PAL_3 = 12'h232;

  function automatic logic [11:0] lcd_pal(input logic [1:0] px);
    case (px)
      2'd0:    return LCD_PAL_0;
      2'd1:    return LCD_PAL_1;
      2'd2:    return LCD_PAL_2;
      default: return LCD_PAL_3;
    endcase
  endfunction

endpackage

// File: rtl/supervision_vram_arb_if.sv
// VRAM client bus: scan-out read port plus the CPU request/ack port.
interface supervision_vram_arb_if;
  import supervision_pkg::*;

  logic [VRAM_AW-1:0] vid_addr;
  logic               vid_slot;
  logic [VRAM_DW-1:0] vid_data;
  logic               vid_miss;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [VRAM_DW-1:0] cpu_din;
  logic               cpu_we;
  logic               cpu_req;
  logic               cpu_busy;
  logic               cpu_ack;
  logic [VRAM_DW-1:0] cpu_dout;
  logic               cpu_drop;

  modport master (
    output vid_addr, vid_slot, cpu_addr, cpu_din, cpu_we, cpu_req,
    input  vid_data, vid_miss, cpu_busy, cpu_ack, cpu_dout, cpu_drop
  );

  modport slave (
    input  vid_addr, vid_slot, cpu_addr, cpu_din, cpu_we, cpu_req,
    output vid_data, vid_miss, cpu_busy, cpu_ack, cpu_dout, cpu_drop
  );

endinterface

// File: rtl/vram_spram.sv
// 8192x8 single-port synchronous RAM with registered read; written plainly
// so synthesis maps it onto a block RAM.
module vram_spram
  import supervision_pkg::*;
(
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [VRAM_AW-1:0] addr_i,
  input  logic [VRAM_DW-1:0] din_i,
  output logic [VRAM_DW-1:0] dout_o
);

  logic [VRAM_DW-1:0] mem_q [VRAM_DEPTH];
  logic [VRAM_DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= din_i;
      else      rd_q          <= mem_q[addr_i];
    end
  end

  assign dout_o = rd_q;

endmodule

// File: rtl/supervision_vram_arb.sv
// VRAM arbiter: video scan-out owns every slot it asks for, the CPU uses
// free cycles through a one-entry buffer and may steal one slot when starved.
module supervision_vram_arb
  import supervision_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  supervision_vram_arb_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_e         state_q;
  logic [7:0]         starve_q;
  logic [VRAM_AW-1:0] buf_addr_q;
  logic [VRAM_DW-1:0] buf_din_q;
  logic               buf_we_q;
  logic               busy_q, ack_q, drop_q, miss_q;
  logic               vid_rd_q, cpu_rd_q;
  logic [VRAM_DW-1:0] vid_data_q, cpu_dout_q;
  logic [VRAM_DW-1:0] ram_rd;

  logic               grant_d, accept_d, ram_en_d, ram_we_d;
  logic [VRAM_AW-1:0] ram_addr_d;

  // A granted CPU access takes the port even if video asked for it this cycle
  always_comb begin
    grant_d    = (state_q == PEND) && (!bus.vid_slot || (starve_q == LIMIT));
    accept_d   = bus.cpu_req && (state_q != PEND);
    ram_en_d   = grant_d || bus.vid_slot;
    ram_we_d   = grant_d && buf_we_q;
    ram_addr_d = grant_d ? buf_addr_q : bus.vid_addr;
  end

  vram_spram u_ram (
    .clk    (clk),
    .en_i   (ram_en_d),
    .we_i   (ram_we_d),
    .addr_i (ram_addr_d),
    .din_i  (buf_din_q),
    .dout_o (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (accept_d) begin
      buf_addr_q <= bus.cpu_addr;
      buf_din_q  <= bus.cpu_din;
      buf_we_q   <= bus.cpu_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
      miss_q     <= 1'b0;
      vid_rd_q   <= 1'b0;
      cpu_rd_q   <= 1'b0;
      vid_data_q <= '0;
      cpu_dout_q <= '0;
    end else begin
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
      cpu_rd_q <= 1'b0;
      miss_q   <= bus.vid_slot && grant_d;
      vid_rd_q <= bus.vid_slot && !grant_d;
      if (vid_rd_q) vid_data_q <= ram_rd;
      if (cpu_rd_q) cpu_dout_q <= ram_rd;

      case (state_q)
        IDLE, DONE: begin
          if (bus.cpu_req) begin
            state_q  <= PEND;
            starve_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        PEND: begin
          if (bus.cpu_req) drop_q <= 1'b1;
          if (grant_d) begin
            state_q  <= DONE;
            ack_q    <= 1'b1;
            cpu_rd_q <= !buf_we_q;
          end else if (starve_q != LIMIT) begin
            starve_q <= starve_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is forwarded straight from the RAM in its first valid cycle, then held
  assign bus.vid_data = vid_rd_q ? ram_rd : vid_data_q;
  assign bus.cpu_dout = cpu_rd_q ? ram_rd : cpu_dout_q;
  assign bus.vid_miss = miss_q;
  assign bus.cpu_busy = busy_q;
  assign bus.cpu_ack  = ack_q;
  assign bus.cpu_drop = drop_q;

endmodule
